sprite_draw_engine: RTL and testbench



---
 rtl/sprite_draw_engine_pkg.sv | 31 +++
 rtl/sprite_draw_engine_if.sv | 30 +++
 rtl/sprite_draw_engine_lut.sv | 27 ++
 rtl/sprite_draw_engine.sv | 135 +++++++++++++
 tb/tb_sprite_draw_engine.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_draw_engine_pkg.sv
// Shared constants for the sprite draw engine.
// States, screen limits, sprite IDs and size bundle.
package draw_pkg;

    localparam int ROM_ADDR_W = 12;

    localparam logic [8:0]  SCREEN_W    = 9'd240;
    localparam logic [9:0]  SCREEN_H    = 10'd320;
    localparam logic [15:0] TRANSPARENT = 16'hF81F;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SIZE  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [3:0] ID_PLAYER0    = 4'd0;
    localparam logic [3:0] ID_PLAYER1    = 4'd1;
    localparam logic [3:0] ID_PLAYER2    = 4'd2;
    localparam logic [3:0] ID_FLOOR      = 4'd5;
    localparam logic [3:0] ID_OBSTACLE   = 4'd6;
    localparam logic [3:0] ID_BACKGROUND = 4'd15;

    typedef struct packed {
        logic [6:0] width;
        logic [6:0] height;
    } sprite_size_t;

endpackage

// File: rtl/sprite_draw_engine_if.sv
// Draw request, sprite ROM and LT24 pixel-write signals.
// slave = engine view, master = controller/ROM/LCD view.
interface sprite_draw_engine_if;
    import draw_pkg::*;

    logic                  draw;
    logic [7:0]            xOrigin;
    logic [8:0]            yOrigin;
    logic [3:0]            ROMId;
    logic                  ready;
    logic [3:0]            romId;
    logic [ROM_ADDR_W-1:0] romAddr;
    logic [15:0]           romData;
    logic                  pixelWrite;
    logic                  pixelReady;
    logic [7:0]            xAddr;
    logic [8:0]            yAddr;
    logic [15:0]           pixelData;

    modport slave (
        input  draw, xOrigin, yOrigin, ROMId, romData, pixelReady,
        output ready, romId, romAddr, pixelWrite, xAddr, yAddr, pixelData
    );

    modport master (
        output draw, xOrigin, yOrigin, ROMId, romData, pixelReady,
        input  ready, romId, romAddr, pixelWrite, xAddr, yAddr, pixelData
    );

endinterface

// File: rtl/sprite_draw_engine_lut.sv
// Sprite dimensions by ROM bank; unknown IDs are empty.
// Purely combinational, read during the SIZE state.
module sprite_size_lut
    import draw_pkg::*;
(
    input  logic [3:0]   id,
    output sprite_size_t size
);

    // Map sprite select to width/height.
    always_comb begin
        size = '0;
        unique case (id)
            ID_PLAYER0, ID_PLAYER1, ID_PLAYER2,
            ID_FLOOR, ID_OBSTACLE: begin
                size.width  = 7'd32;
                size.height = 7'd64;
            end
            ID_BACKGROUND: begin
                size.width  = 7'd1;
                size.height = 7'd1;
            end
            default: size = '0;
        endcase
    end

endmodule

// File: rtl/sprite_draw_engine.sv
// Walks one sprite ROM and emits visible pixels to the LT24 port.
// ROM address is a running counter, so no row*width multiply.
module sprite_draw_engine
    import draw_pkg::*;
(
    input logic                 clock,
    input logic                 reset,
    sprite_draw_engine_if.slave bus
);

    logic [2:0]            state;
    logic                  drawPrev;
    logic                  readyR;
    logic [3:0]            romIdR;
    logic [ROM_ADDR_W-1:0] addrR;
    logic [7:0]            xOrg;
    logic [8:0]            yOrg;
    logic [5:0]            col;
    logic [5:0]            row;
    logic [6:0]            width;
    logic [6:0]            height;
    logic                  writeR;
    logic [7:0]            xR;
    logic [8:0]            yR;
    logic [15:0]           dataR;
    sprite_size_t          size;
    logic [8:0]            px;
    logic [9:0]            py;
    logic                  visible;
    logic                  lastCol;
    logic                  lastRow;

    sprite_size_lut u_lut (
        .id   (romIdR),
        .size (size)
    );

    assign bus.ready      = readyR;
    assign bus.romId      = romIdR;
    assign bus.romAddr    = addrR;
    assign bus.pixelWrite = writeR;
    assign bus.xAddr      = xR;
    assign bus.yAddr      = yR;
    assign bus.pixelData  = dataR;

    // Screen position of the current pixel and walk-end flags.
    always_comb begin
        px      = {1'b0, xOrg} + {3'b0, col};
        py      = {1'b0, yOrg} + {4'b0, row};
        visible = (bus.romData != TRANSPARENT) &&
                  (px < SCREEN_W) && (py < SCREEN_H);
        lastCol = ({1'b0, col} == width - 7'd1);
        lastRow = ({1'b0, row} == height - 7'd1);
    end

    // Request capture, ROM walk and pixel handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            drawPrev <= 1'b1;
            readyR   <= 1'b1;
            romIdR   <= '0;
            addrR    <= '0;
            xOrg     <= '0;
            yOrg     <= '0;
            col      <= '0;
            row      <= '0;
            width    <= '0;
            height   <= '0;
            writeR   <= 1'b0;
            xR       <= '0;
            yR       <= '0;
            dataR    <= '0;
        end else begin
            drawPrev <= bus.draw;
            case (state)
                S_IDLE: begin
                    if (bus.draw && !drawPrev) begin
                        xOrg   <= bus.xOrigin;
                        yOrg   <= bus.yOrigin;
                        romIdR <= bus.ROMId;
                        addrR  <= '0;
                        col    <= '0;
                        row    <= '0;
                        readyR <= 1'b0;
                        state  <= S_SIZE;
                    end
                end
                S_SIZE: begin
                    width  <= size.width;
                    height <= size.height;
                    if (size.width == '0 || size.height == '0)
                        state <= S_DONE;
                    else
                        state <= S_FETCH;
                end
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    if (visible) begin
                        xR     <= px[7:0];
                        yR     <= py[8:0];
                        dataR  <= bus.romData;
                        writeR <= 1'b1;
                        state  <= S_WRITE;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_WRITE: begin
                    if (bus.pixelReady) begin
                        writeR <= 1'b0;
                        state  <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    addrR <= addrR + 1'b1;
                    if (lastCol) begin
                        col <= '0;
                        row <= row + 6'd1;
                        state <= lastRow ? S_DONE : S_FETCH;
                    end else begin
                        col   <= col + 6'd1;
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    readyR <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Scoreboard bench for sprite_draw_engine.
// Expected pixel writes are queued per draw and popped on accept.
module tb_sprite_draw_engine;
    import draw_pkg::*;

    logic clock = 1'b0;
    logic reset;

    sprite_draw_engine_if bus();

    sprite_draw_engine dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clock = ~clock;

    int nCmp = 0;
    int nBad = 0;
    int cyc = 0;
    int wrCount = 0;
    int accCyc = 0;
    int romMode = 0;
    bit randReady = 1'b0;
    logic [32:0] expQ[$];
    logic [32:0] firstW;
    logic [32:0] lastW;
    logic [32:0] held;
    logic        stallPrev = 1'b0;

    function automatic logic [15:0] rom_fn(input int mode, input logic [11:0] a);
        if (mode == 0) return 16'h07E0;
        return (a[5] ^ a[0]) ? 16'h001F : 16'hF81F;
    endfunction

    function automatic int sz_w(input logic [3:0] id);
        if (id inside {4'd0, 4'd1, 4'd2, 4'd5, 4'd6}) return 32;
        if (id == 4'd15) return 1;
        return 0;
    endfunction

    function automatic int sz_h(input logic [3:0] id);
        if (id inside {4'd0, 4'd1, 4'd2, 4'd5, 4'd6}) return 64;
        if (id == 4'd15) return 1;
        return 0;
    endfunction

    always @(posedge clock) cyc++;

    always @(posedge clock) bus.romData <= rom_fn(romMode, bus.romAddr);

    always @(posedge clock) begin
        #1;
        bus.pixelReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Pixel monitor: stability while stalled, scoreboard on accept.
    always @(negedge clock) begin
        logic [32:0] got;
        logic [32:0] exp;
        got = {bus.xAddr, bus.yAddr, bus.pixelData};
        if (reset) begin
            stallPrev = 1'b0;
        end else begin
            if (stallPrev && bus.pixelWrite) begin
                nCmp++;
                if (got !== held) begin
                    nBad++;
                    $display("FAIL stall_stable: got %h required %h", got, held);
                end
            end
            if (bus.pixelWrite && bus.pixelReady) begin
                nCmp++;
                if (expQ.size() == 0) begin
                    nBad++;
                    $display("FAIL unexpected_write: got %h required none", got);
                end else begin
                    exp = expQ.pop_front();
                    if (got !== exp) begin
                        nBad++;
                        $display("FAIL pixel_write: got %h required %h", got, exp);
                    end
                end
                if (wrCount == 0) firstW = got;
                lastW = got;
                wrCount++;
                accCyc = cyc;
            end
            stallPrev = bus.pixelWrite && !bus.pixelReady;
            held = got;
        end
    end

    task automatic push_model(input int x, input int y, input logic [3:0] id);
        int w;
        int h;
        int a;
        logic [15:0] d;
        logic [7:0] xv;
        logic [8:0] yv;
        w = sz_w(id);
        h = sz_h(id);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                a = r * w + c;
                d = rom_fn(romMode, a[11:0]);
                if (d != 16'hF81F && x + c < 240 && y + r < 320) begin
                    xv = 8'(x + c);
                    yv = 9'(y + r);
                    expQ.push_back({xv, yv, d});
                end
            end
        end
    endtask

    task automatic start_draw(input int x, input int y, input logic [3:0] id);
        bit seen;
        @(posedge clock);
        #1;
        bus.xOrigin = 8'(x);
        bus.yOrigin = 9'(y);
        bus.ROMId = id;
        bus.draw = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            if (bus.ready === 1'b0) seen = 1'b1;
        end
        nCmp++;
        if (!seen) begin
            nBad++;
            $display("FAIL ready_drop: got ready=1 required 0");
        end
        @(posedge clock);
        #1;
        bus.draw = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40000 && !seen; i++) begin
            @(negedge clock);
            if (bus.ready === 1'b1) seen = 1'b1;
        end
        nCmp++;
        if (!seen) begin
            nBad++;
            $display("FAIL %s_timeout: got ready=0 required 1", nm);
        end
    endtask

    task automatic run_draw(input int x, input int y, input logic [3:0] id,
                            input int nExp, input string nm);
        wrCount = 0;
        push_model(x, y, id);
        start_draw(x, y, id);
        wait_idle(nm);
        nCmp++;
        if (wrCount != nExp) begin
            nBad++;
            $display("FAIL %s_count: got %0d required %0d", nm, wrCount, nExp);
        end
        nCmp++;
        if (expQ.size() != 0) begin
            nBad++;
            $display("FAIL %s_leftover: got %0d required 0", nm, expQ.size());
        end
        expQ.delete();
    endtask

    task automatic test_reset;
        bit bad;
        reset = 1'b1;
        bus.draw = 1'b1;
        bus.xOrigin = '0;
        bus.yOrigin = '0;
        bus.ROMId = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        nCmp++;
        if ({bus.ready, bus.pixelWrite, bus.romAddr, bus.romId} !== {1'b1, 1'b0, 12'd0, 4'd0}) begin
            nBad++;
            $display("FAIL reset_ctl: got %b/%b/%h/%h required 1/0/000/0",
                     bus.ready, bus.pixelWrite, bus.romAddr, bus.romId);
        end
        nCmp++;
        if ({bus.xAddr, bus.yAddr, bus.pixelData} !== 33'd0) begin
            nBad++;
            $display("FAIL reset_pix: got %h required 0",
                     {bus.xAddr, bus.yAddr, bus.pixelData});
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        wrCount = 0;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (bus.ready !== 1'b1 || bus.pixelWrite !== 1'b0) bad = 1'b1;
        end
        nCmp++;
        if (bad || wrCount != 0) begin
            nBad++;
            $display("FAIL held_draw: got started required idle");
        end
        @(posedge clock);
        #1;
        bus.draw = 1'b0;
        repeat (2) @(posedge clock);
        romMode = 0;
        run_draw(0, 0, 4'd15, 1, "bg_fill");
    endtask

    task automatic test_solid;
        romMode = 0;
        run_draw(10, 20, 4'd6, 2048, "solid");
        nCmp++;
        if (firstW !== {8'd10, 9'd20, 16'h07E0}) begin
            nBad++;
            $display("FAIL solid_first: got %h required %h", firstW, {8'd10, 9'd20, 16'h07E0});
        end
        nCmp++;
        if (lastW !== {8'd41, 9'd83, 16'h07E0}) begin
            nBad++;
            $display("FAIL solid_last: got %h required %h", lastW, {8'd41, 9'd83, 16'h07E0});
        end
        nCmp++;
        if (cyc - accCyc != 3) begin
            nBad++;
            $display("FAIL ready_latency: got %0d required 3", cyc - accCyc);
        end
    endtask

    task automatic test_checker;
        romMode = 1;
        run_draw(10, 20, 4'd6, 1024, "checker");
    endtask

    task automatic test_clip;
        romMode = 0;
        run_draw(220, 300, 4'd6, 400, "clip");
        nCmp++;
        if (lastW !== {8'd239, 9'd319, 16'h07E0}) begin
            nBad++;
            $display("FAIL clip_last: got %h required %h", lastW, {8'd239, 9'd319, 16'h07E0});
        end
    endtask

    task automatic test_empty;
        romMode = 0;
        run_draw(5, 5, 4'd9, 0, "empty");
    endtask

    task automatic test_stall;
        romMode = 0;
        randReady = 1'b1;
        run_draw(10, 20, 4'd6, 2048, "stall");
        randReady = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit hit;
        romMode = 0;
        wrCount = 0;
        push_model(10, 20, 4'd6);
        start_draw(10, 20, 4'd6);
        hit = 1'b0;
        for (int i = 0; i < 10000 && !hit; i++) begin
            @(negedge clock);
            if (wrCount >= 500) hit = 1'b1;
        end
        nCmp++;
        if (!hit) begin
            nBad++;
            $display("FAIL mid_reach: got %0d writes required 500", wrCount);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        nCmp++;
        if ({bus.pixelWrite, bus.ready, bus.romAddr} !== {1'b0, 1'b1, 12'd0}) begin
            nBad++;
            $display("FAIL mid_reset: got %b/%b/%h required 0/1/000",
                     bus.pixelWrite, bus.ready, bus.romAddr);
        end
        expQ.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        romMode = 1;
        run_draw(10, 20, 4'd6, 1024, "restart");
    endtask

    initial begin
        test_reset;
        test_solid;
        test_checker;
        test_clip;
        test_empty;
        test_stall;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
